execute_stage_pipe: RTL and testbench

//  Parametrised execute stage: ID/EX register, ALU, memory-data steering and EX/MEM register in one block.

---
 rtl/exec_pkg.sv | 16 +
 rtl/execute_stage_pipe_if.sv | 21 ++
 rtl/exec_mul_seq.sv | 39 +++
 rtl/execute_stage_pipe.sv | 90 +++++++++
 tb/tb_execute_stage_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared ALU opcodes, packed pass-through control word and execute-stage FSM states.
package exec_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_MUL, OP_PASSB} alu_op_e;
  typedef struct packed {
    logic       wbs;
    logic [1:0] mm;
    logic       wm;
    logic       am;
    logic       ni;
    logic       wce;
    logic       wme1;
    logic       wme2;
    logic       rsv;
  } ctrl_t;
  typedef enum logic [1:0] {IDLE, EXEC, MBUSY} exec_state_e;
endpackage

// File: rtl/execute_stage_pipe_if.sv
// execute_stage_pipe_if: decode-side and memory-side handshakes of the execute stage.
interface execute_stage_pipe_if #(parameter int WIDTH = 16, parameter int CTRL_W = 10);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_op;
  logic [CTRL_W-1:0] ctrl_in;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] ctrl_out;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  mem_data;
  logic              flag_n;
  logic              flag_z;
  modport master (output flush, in_valid, alu_op, ctrl_in, src_a, src_b, out_ready,
                  input in_ready, out_valid, ctrl_out, result, mem_data, flag_n, flag_z);
  modport slave  (input flush, in_valid, alu_op, ctrl_in, src_a, src_b, out_ready,
                  output in_ready, out_valid, ctrl_out, result, mem_data, flag_n, flag_z);
endinterface

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: iterative shift-add multiplier, one partial product per cycle over WIDTH cycles (EXEC_MUL_EN builds only).
`ifdef EXEC_MUL_EN
module exec_mul_seq #(parameter int WIDTH = 16) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] r_acc, r_mc, r_mp;
  logic [CW-1:0]    r_cnt;
  // done flags the final iteration, which lands on the coming edge
  assign o_done = r_cnt == CW'(1);
  assign o_prod = r_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_acc <= '0;
      r_mc  <= '0;
      r_mp  <= '0;
      r_cnt <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_acc <= '0;
      r_mc  <= i_a;
      r_mp  <= i_b;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc <= r_acc + (r_mp[0] ? r_mc : '0);
      r_mc  <= r_mc << 1;
      r_mp  <= r_mp >> 1;
      r_cnt <= r_cnt - CW'(1);
    end
endmodule
`endif

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: ID/EX slot, ALU, store-data steering and EX/MEM slot with valid/ready, flush and stall.
// EXEC_MUL_EN enables the iterative multiplier; otherwise op 110 acts as PASS_B in a single cycle.
module execute_stage_pipe
  import exec_pkg::*;
#(parameter int WIDTH = 16, parameter int CTRL_W = 10) (
  input logic                 clk,
  input logic                 rst_n,
  execute_stage_pipe_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  exec_state_e      r_state, w_state_nxt;
  alu_op_e          r_op;
  ctrl_t            r_ctrl, r_out_ctrl;
  logic [WIDTH-1:0] r_a, r_b, r_result, r_mem_data, w_alu, w_mul_prod;
  logic             r_out_valid, r_flag_n, r_flag_z;
  logic             w_out_free, w_accept, w_move, w_mul_start, w_mul_done;
  assign w_out_free   = !r_out_valid || bus.out_ready;
  assign bus.in_ready = !bus.flush && (r_state == IDLE || (r_state == EXEC && w_out_free));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_move       = !bus.flush && r_state == EXEC && w_out_free;
`ifdef EXEC_MUL_EN
  assign w_mul_start = w_accept && alu_op_e'(bus.alu_op) == OP_MUL;
  exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk, .rst_n, .i_start(w_mul_start), .i_abort(bus.flush),
    .i_a(bus.src_a), .i_b(bus.src_b), .o_done(w_mul_done), .o_prod(w_mul_prod)
  );
`else
  assign w_mul_start = 1'b0;
  assign w_mul_done  = 1'b0;
  assign w_mul_prod  = r_b;
`endif
  always_comb begin
    w_alu = r_b;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_SHL:  w_alu = r_a << r_b[SW-1:0];
      OP_SHR:  w_alu = r_a >> r_b[SW-1:0];
      OP_MUL:  w_alu = w_mul_prod;
      default: w_alu = r_b;
    endcase
  end
  // a new accept overrides the drain-to-IDLE because the slot refills on the same edge
  always_comb begin
    w_state_nxt = bus.flush ? IDLE :
                  w_accept ? (w_mul_start ? MBUSY : EXEC) :
                  w_move ? IDLE :
                  (r_state == MBUSY && w_mul_done) ? EXEC : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_ctrl      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_result    <= '0;
      r_mem_data  <= '0;
      r_flag_n    <= 1'b0;
      r_flag_z    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= alu_op_e'(bus.alu_op);
        r_ctrl <= ctrl_t'(bus.ctrl_in);
        r_a    <= bus.src_a;
        r_b    <= bus.src_b;
      end
      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_ctrl  <= r_ctrl;
        r_result    <= w_alu;
        r_mem_data  <= r_ctrl.am ? r_b : '0;
        r_flag_n    <= w_alu[WIDTH-1];
        r_flag_z    <= w_alu == '0;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  assign bus.out_valid = r_out_valid;
  assign bus.ctrl_out  = CTRL_W'(r_out_ctrl);
  assign bus.result    = r_result;
  assign bus.mem_data  = r_mem_data;
  assign bus.flag_n    = r_flag_n;
  assign bus.flag_z    = r_flag_z;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe: directed stimulus with a queue scoreboard drained by an independent output monitor.
module tb_execute_stage_pipe;
  localparam int W  = 16;
  localparam int CW = 10;
`ifdef EXEC_MUL_EN
  localparam logic [W-1:0] MUL_EXP = 16'h03A8;
  localparam int           MUL_LAT = 17;
`else
  localparam logic [W-1:0] MUL_EXP = 16'h0034;
  localparam int           MUL_LAT = 1;
`endif
  typedef struct packed {
    logic [W-1:0]  res;
    logic [W-1:0]  md;
    logic [CW-1:0] ctrl;
    logic          n;
    logic          z;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int popped = 0;
  always #5 clk = ~clk;
  execute_stage_pipe_if #(.WIDTH(W), .CTRL_W(CW)) bus ();
  execute_stage_pipe #(.WIDTH(W), .CTRL_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [CW-1:0] ctrl, input logic [W-1:0] a, b,
                       input logic [W-1:0] eres, emd, input bit push, output int waits);
    logic acc;
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.ctrl_in  = ctrl;
    bus.src_a    = a;
    bus.src_b    = b;
    if (push) q.push_back('{eres, emd, ctrl, eres[W-1], eres == '0});
    waits = 0;
    acc = 1'b0;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: got in_ready=0 for %0d cycles expected accept", waits);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_extra: got result %0h expected no output", bus.result);
        end else begin
          e = q.pop_front();
          popped++;
          chk("sb_result", bus.result, e.res);
          chk("sb_mem_data", bus.mem_data, e.md);
          chk("sb_ctrl", bus.ctrl_out, e.ctrl);
          chk("sb_flag_n", bus.flag_n, e.n);
          chk("sb_flag_z", bus.flag_z, e.z);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, w2, k, p0;
    bit seen;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_op = '0;
    bus.ctrl_in = '0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags", {bus.flag_n, bus.flag_z}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(3'b000, 10'h000, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1, w);
    tick(1);
    chk("lat_add", bus.out_valid, 1);
    issue(3'b001, 10'h000, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 1, w);
    issue(3'b011, 10'h000, 16'h0050, 16'h0007, 16'h0057, 16'h0000, 1, w);
    issue(3'b100, 10'h000, 16'h0001, 16'h001F, 16'h8000, 16'h0000, 1, w2);
    chk("b2b_or_cycles", w, 1);
    chk("b2b_shl_cycles", w2, 1);
    issue(3'b101, 10'h000, 16'h8000, 16'h0034, 16'h0800, 16'h0000, 1, w);
    issue(3'b001, 10'h000, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1, w);
    issue(3'b000, 10'h000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1, w);
    issue(3'b000, 10'h2A5, 16'h0010, 16'h00FF, 16'h010F, 16'h00FF, 1, w);
    issue(3'b010, 10'h185, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1, w);
    issue(3'b111, 10'h3FF, 16'h1234, 16'hABCD, 16'hABCD, 16'hABCD, 1, w);
    tick(3);
    chk("drain_idle", bus.out_valid, 0);
    p0 = popped;
    bus.out_ready = 1'b0;
    issue(3'b000, 10'h001, 16'h0001, 16'h0001, 16'h0002, 16'h0000, 1, w);
    issue(3'b011, 10'h002, 16'h0100, 16'h0001, 16'h0101, 16'h0000, 1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_result", bus.result, 16'h0002);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    tick(4);
    chk("stall_count", popped - p0, 2);
    p0 = popped;
    bus.out_ready = 1'b0;
    issue(3'b000, 10'h004, 16'h0005, 16'h0005, 16'h000A, 16'h0000, 1, w);
    issue(3'b000, 10'h008, 16'h0007, 16'h0007, 16'h000E, 16'h0000, 0, w);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.src_a = 16'h0009;
    bus.src_b = 16'h0009;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    tick(1);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_ready", bus.in_ready, 1);
    chk("flush_keep_result", bus.result, 16'h000A);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    tick(4);
    chk("flush_count", popped - p0, 1);
    chk("flush_drained", bus.out_valid, 0);
    issue(3'b110, 10'h010, 16'h0012, 16'h0034, MUL_EXP, 16'h0000, 1, w);
    k = 0;
    do begin
      tick(1);
      k++;
    end while (!bus.out_valid && k < 40);
    chk("mul_latency", k, MUL_LAT);
    tick(2);
`ifdef EXEC_MUL_EN
    issue(3'b110, 10'h000, 16'h0003, 16'h0004, 16'h000C, 16'h0000, 0, w);
    tick(4);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("mul_flush_no_out", seen, 0);
    chk("mul_flush_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
`endif
    bus.out_ready = 1'b0;
    issue(3'b000, 10'h3FF, 16'h0011, 16'h0022, 16'h0033, 16'h0022, 1, w);
    issue(3'b011, 10'h000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 1, w);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_mem_data", bus.mem_data, 0);
    chk("mid_rst_ctrl", bus.ctrl_out, 0);
    chk("mid_rst_flags", {bus.flag_n, bus.flag_z}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
